// File: rtl/video_rx_pkg.sv
// Shared constants for the video receive/capture path.
//  - FSM state encoding for video_rx_capture
//  - alpha nibble forced into every captured pixel word
package video_rx_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_VS = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [3:0] ALPHA = 4'hF;
    localparam int unsigned RGB_W = 12;

endpackage

// File: rtl/video_rx_fifo.sv
// Single-clock first-word-fall-through FIFO buffering captured pixels.
// Ports:
//  clk, rst_n       clock, async active-low reset (pointers flushed)
//  push, wr_data    write request and data; accepted when not full or popping
//  pop              read request; rd_data_c shows the head word combinationally
//  full_c, empty_c  combinational status flags
module video_rx_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Push on a full FIFO is legal when the head leaves in the same cycle.
    assign wr_en     = push && (!full_c || pop);
    assign rd_en     = pop && !empty_c;
    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/video_rx_capture.sv
// Parallel TFT video receiver: registers HSync/VSync/DE/RGB444, checks frame
// geometry and writes active pixels to alternating SRAM frame buffers over a
// Ufi master write port.
// Ports:
//  iClk, iRst                 clock, async active-low reset
//  iVidHSync/VSync/De/Rgb     video input stream
//  iCapEn                     capture enable level
//  iHdisplay, iVdisplay       expected pixels/line and lines/frame
//  iFbufAdrs1/2               frame buffer base addresses
//  oMUfi*, iMUfiRdy           Ufi write master
//  oFrameDone, oBufSel        frame completion pulse, buffer being written
//  oMeasH/V, oFmtErr, oOvf    measured geometry and sticky error flags
module video_rx_capture
    import video_rx_pkg::*;
#(
    parameter int unsigned pUfiBusWidth   = 16,
    parameter int unsigned pMemAdrsWidth  = 19,
    parameter int unsigned pHdisplayWidth = 11,
    parameter int unsigned pVdisplayWidth = 11,
    parameter int unsigned pFifoDepth     = 32,
    parameter string       pSyncActiveLow = "yes"
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iVidHSync,
    input  logic                      iVidVSync,
    input  logic                      iVidDe,
    input  logic [RGB_W-1:0]          iVidRgb,
    input  logic                      iCapEn,
    input  logic [pHdisplayWidth-1:0] iHdisplay,
    input  logic [pVdisplayWidth-1:0] iVdisplay,
    input  logic [pMemAdrsWidth-1:0]  iFbufAdrs1,
    input  logic [pMemAdrsWidth-1:0]  iFbufAdrs2,
    output logic [pUfiBusWidth-1:0]   oMUfiWd,
    output logic [pMemAdrsWidth-1:0]  oMUfiAdrs,
    output logic                      oMUfiWEd,
    output logic                      oMUfiREd,
    output logic                      oMUfiVd,
    output logic                      oMUfiCmd,
    input  logic                      iMUfiRdy,
    output logic                      oFrameDone,
    output logic                      oBufSel,
    output logic [pHdisplayWidth-1:0] oMeasH,
    output logic [pVdisplayWidth-1:0] oMeasV,
    output logic                      oFmtErr,
    output logic                      oOvf
);

    localparam logic SYNC_LOW = (pSyncActiveLow == "yes");

    logic                      vs_r, vs_d, de_r, de_d;
    logic [RGB_W-1:0]          rgb_r;
    logic                      vs_rise, de_fall;
    logic [2:0]                state, next_state;
    logic                      fifo_full, fifo_empty;
    logic [pUfiBusWidth-1:0]   fifo_data;
    logic                      cap_pix, push, drop, load, drain_done;
    logic                      cap_start, frame_end;
    logic [pHdisplayWidth-1:0] pix_cnt, last_w;
    logic [pVdisplayWidth-1:0] line_cnt;
    logic [pMemAdrsWidth-1:0]  offset;
    logic                      ovf_frame, abort_q;
    logic                      unused_hsync;

    // Line boundaries are taken from DE; HSync carries no extra information here.
    assign unused_hsync = iVidHSync;

    // Input register; syncs normalised to active-high
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            de_r  <= 1'b0;
            de_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            vs_r  <= iVidVSync ^ SYNC_LOW;
            vs_d  <= vs_r;
            de_r  <= iVidDe;
            de_d  <= de_r;
            rgb_r <= iVidRgb;
        end
    end

    assign vs_rise    = vs_r && !vs_d;
    assign de_fall    = de_d && !de_r;
    assign cap_pix    = (state == ST_CAPTURE) && de_r;
    // Output stage reloads from the FIFO whenever it is empty or its beat completes.
    assign load       = ((state == ST_CAPTURE) || (state == ST_DRAIN)) && !fifo_empty
                        && (!oMUfiVd || iMUfiRdy);
    assign push       = cap_pix && !ovf_frame && (!fifo_full || load);
    assign drop       = cap_pix && !ovf_frame && fifo_full && !load;
    assign drain_done = fifo_empty && !oMUfiVd;
    assign cap_start  = (state == ST_WAIT_VS) && (next_state == ST_CAPTURE);
    assign frame_end  = (state == ST_DRAIN) && (next_state == ST_DONE);

    video_rx_fifo #(
        .DEPTH (pFifoDepth),
        .WIDTH (pUfiBusWidth)
    ) u_fifo (
        .clk       (iClk),
        .rst_n     (iRst),
        .push      (push),
        .wr_data   (pUfiBusWidth'({ALPHA, rgb_r})),
        .pop       (load),
        .rd_data_c (fifo_data),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    // State register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (iCapEn) next_state = ST_WAIT_VS;
            ST_WAIT_VS: begin
                if (!iCapEn)      next_state = ST_IDLE;
                else if (vs_rise) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: if (!iCapEn || vs_rise) next_state = ST_DRAIN;
            ST_DRAIN:   if (drain_done) next_state = abort_q ? ST_IDLE : ST_DONE;
            ST_DONE:    next_state = iCapEn ? ST_WAIT_VS : ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Geometry counters, status flags and Ufi output stage
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pix_cnt    <= '0;
            last_w     <= '0;
            line_cnt   <= '0;
            offset     <= '0;
            ovf_frame  <= 1'b0;
            abort_q    <= 1'b0;
            oMUfiVd    <= 1'b0;
            oMUfiWd    <= '0;
            oMUfiAdrs  <= '0;
            oFrameDone <= 1'b0;
            oBufSel    <= 1'b0;
            oMeasH     <= '0;
            oMeasV     <= '0;
            oFmtErr    <= 1'b0;
            oOvf       <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            if (cap_start) begin
                pix_cnt   <= '0;
                last_w    <= '0;
                line_cnt  <= '0;
                offset    <= '0;
                ovf_frame <= 1'b0;
                abort_q   <= 1'b0;
            end
            if (state == ST_CAPTURE) begin
                if (de_r) pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
                if (de_fall) begin
                    line_cnt <= (&line_cnt) ? line_cnt : line_cnt + 1'b1;
                    last_w   <= pix_cnt;
                    pix_cnt  <= '0;
                    if (pix_cnt != iHdisplay) oFmtErr <= 1'b1;
                end
                if (!iCapEn) abort_q <= 1'b1;
            end
            // After the first drop the rest of the frame is discarded, so the
            // beats that do get written keep their true buffer offsets.
            if (drop) begin
                ovf_frame <= 1'b1;
                oOvf      <= 1'b1;
            end
            if (load) begin
                oMUfiVd   <= 1'b1;
                oMUfiWd   <= fifo_data;
                oMUfiAdrs <= (oBufSel ? iFbufAdrs2 : iFbufAdrs1) + offset;
                offset    <= offset + 1'b1;
            end else if (iMUfiRdy) begin
                oMUfiVd <= 1'b0;
            end
            if (frame_end) begin
                oMeasH     <= last_w;
                oMeasV     <= line_cnt;
                oFrameDone <= 1'b1;
                oBufSel    <= !oBufSel;
                offset     <= '0;
                if (line_cnt != iVdisplay) oFmtErr <= 1'b1;
            end
            if ((state == ST_IDLE) && !iCapEn) begin
                oFmtErr <= 1'b0;
                oOvf    <= 1'b0;
            end
        end
    end

    assign oMUfiWEd = oMUfiVd;
    assign oMUfiREd = 1'b0;
    assign oMUfiCmd = 1'b0;

endmodule

// File: tb/tb_video_rx_capture.sv
// Self-checking bench for video_rx_capture: randomized pixel data, a queue of
// expected (address, data) beats built from the frame geometry, and checks of
// geometry flags, buffer alternation, overflow, abort and reset behaviour.
// Two instances cover both sync polarities with identical stimulus.
module tb_video_rx_capture;

    typedef struct packed {
        logic [18:0] a;
        logic [15:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, hs, vs, de, cap_en, rdy;
    logic [11:0] rgb;
    logic [10:0] hdisp, vdisp;
    logic [18:0] a1, a2;

    logic [15:0] wd, h_wd;
    logic [18:0] adrs, h_adrs;
    logic        wed, red, vd, cmd, fdone, bsel, ferr, ovf;
    logic        h_wed, h_red, h_vd, h_cmd, h_fdone, h_bsel, h_ferr, h_ovf;
    logic [10:0] mh, mv, h_mh, h_mv;
    logic        hs_n, vs_n;

    int    errs = 0, checks = 0;
    int    fd_cnt = 0, h_fd_cnt = 0, n_wr = 0;
    int    exp_idx = 0, stall_left = 0;
    bit    exp_buf = 1'b0;
    beat_t q_lo[$];
    beat_t q_hi[$];

    always #5 clk = ~clk;

    assign hs_n = ~hs;
    assign vs_n = ~vs;

    video_rx_capture #(.pSyncActiveLow("yes")) dut_lo (
        .iClk(clk), .iRst(rst_n), .iVidHSync(hs_n), .iVidVSync(vs_n), .iVidDe(de),
        .iVidRgb(rgb), .iCapEn(cap_en), .iHdisplay(hdisp), .iVdisplay(vdisp),
        .iFbufAdrs1(a1), .iFbufAdrs2(a2), .oMUfiWd(wd), .oMUfiAdrs(adrs),
        .oMUfiWEd(wed), .oMUfiREd(red), .oMUfiVd(vd), .oMUfiCmd(cmd), .iMUfiRdy(rdy),
        .oFrameDone(fdone), .oBufSel(bsel), .oMeasH(mh), .oMeasV(mv),
        .oFmtErr(ferr), .oOvf(ovf)
    );

    video_rx_capture #(.pSyncActiveLow("no")) dut_hi (
        .iClk(clk), .iRst(rst_n), .iVidHSync(hs), .iVidVSync(vs), .iVidDe(de),
        .iVidRgb(rgb), .iCapEn(cap_en), .iHdisplay(hdisp), .iVdisplay(vdisp),
        .iFbufAdrs1(a1), .iFbufAdrs2(a2), .oMUfiWd(h_wd), .oMUfiAdrs(h_adrs),
        .oMUfiWEd(h_wed), .oMUfiREd(h_red), .oMUfiVd(h_vd), .oMUfiCmd(h_cmd), .iMUfiRdy(rdy),
        .oFrameDone(h_fdone), .oBufSel(h_bsel), .oMeasH(h_mh), .oMeasV(h_mv),
        .oFmtErr(h_ferr), .oOvf(h_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = 1'b1;
        end
    endtask

    task automatic push_exp(input logic [11:0] p);
        beat_t b;
        b.a = (exp_buf ? a2 : a1) + 19'(exp_idx);
        b.d = 16'({4'hF, p});
        q_lo.push_back(b);
        q_hi.push_back(b);
        exp_idx++;
    endtask

    task automatic vsync_pulse();
        vs = 1'b1;
        repeat (2) cyc();
        vs = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic send_line(input int w, input bit expect_it, input int stall_pix);
        for (int i = 0; i < w; i++) begin
            if (i == stall_pix) stall_left = 40;
            de  = 1'b1;
            rgb = 12'($urandom_range(0, 4095));
            if (expect_it) push_exp(rgb);
            cyc();
        end
        de  = 1'b0;
        rgb = '0;
        cyc();
        hs = 1'b1;
        cyc();
        hs = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic start_frame();
        vsync_pulse();
        exp_idx = 0;
    endtask

    // Closing VSync, then a bounded wait for both instances to report the frame.
    task automatic end_frame(input bit expect_all);
        int c0, h0, t;
        c0 = fd_cnt;
        h0 = h_fd_cnt;
        vsync_pulse();
        t = 0;
        while ((fd_cnt == c0 || h_fd_cnt == h0) && t < 400) begin
            cyc();
            t++;
        end
        check_val("frame_done", 32'(fd_cnt - c0), 1);
        check_val("h_frame_done", 32'(h_fd_cnt - h0), 1);
        exp_buf = ~exp_buf;
        if (expect_all) begin
            check_val("all_written", 32'(q_lo.size()), 0);
            check_val("h_all_written", 32'(q_hi.size()), 0);
        end
        check_val("buf_sel", 32'(bsel), 32'(exp_buf));
        check_val("h_buf_sel", 32'(h_bsel), 32'(exp_buf));
    endtask

    task automatic check_status(input int eh, input int ev, input bit ef, input bit eo);
        check_val("meas_h", 32'(mh), 32'(eh));
        check_val("meas_v", 32'(mv), 32'(ev));
        check_val("fmt_err", 32'(ferr), 32'(ef));
        check_val("ovf", 32'(ovf), 32'(eo));
        check_val("h_status", 32'({h_mh, h_mv, h_ferr, h_ovf}),
                  32'({11'(eh), 11'(ev), ef, eo}));
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_wd"}, 32'(wd), 0);
        check_val({tag, "_adrs"}, 32'(adrs), 0);
        check_val({tag, "_ctl"}, 32'({wed, red, vd, cmd, fdone, bsel, ferr, ovf}), 0);
        check_val({tag, "_meas"}, 32'({mh, mv}), 0);
        check_val({tag, "_h_ctl"}, 32'({h_wed, h_vd, h_fdone, h_bsel, h_ferr, h_ovf}), 0);
    endtask

    // Bus monitor: scoreboard beats, stall stability, frame-done pulse shape
    initial begin
        beat_t e;
        logic  p_vd, p_rdy, p_fd;
        logic [15:0] p_wd;
        logic [18:0] p_adrs;
        p_vd = 1'b0; p_rdy = 1'b1; p_fd = 1'b0; p_wd = '0; p_adrs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_vd = 1'b0; p_rdy = 1'b1; p_fd = 1'b0;
            end else begin
                if (vd && rdy) begin
                    check_val("wr_expected", 32'(q_lo.size() != 0), 1);
                    if (q_lo.size() != 0) begin
                        e = q_lo.pop_front();
                        check_val("wr_adrs", 32'(adrs), 32'(e.a));
                        check_val("wr_data", 32'(wd), 32'(e.d));
                        check_val("wr_strobes", 32'({wed, red, cmd}), 32'b100);
                        n_wr++;
                    end
                end
                if (h_vd && rdy) begin
                    check_val("h_wr_expected", 32'(q_hi.size() != 0), 1);
                    if (q_hi.size() != 0) begin
                        e = q_hi.pop_front();
                        check_val("h_wr_beat", 32'({h_adrs, h_wd[12:0]}), 32'({e.a, e.d[12:0]}));
                        check_val("h_wr_top", 32'({h_wd[15:13], h_wed, h_red, h_cmd}),
                                  32'({e.d[15:13], 3'b100}));
                    end
                end
                if (p_vd && !p_rdy) begin
                    check_val("hold_vd", 32'(vd), 1);
                    check_val("hold_wd", 32'(wd), 32'(p_wd));
                    check_val("hold_adrs", 32'(adrs), 32'(p_adrs));
                end
                if (fdone) begin
                    check_val("fd_pulse", 32'(p_fd), 0);
                    fd_cnt++;
                end
                if (h_fdone) h_fd_cnt++;
                p_vd = vd; p_rdy = rdy; p_wd = wd; p_adrs = adrs; p_fd = fdone;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0;
        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; rgb = '0; cap_en = 1'b0; rdy = 1'b1;
        hdisp = 11'd8; vdisp = 11'd4; a1 = 19'h01000; a2 = 19'h7FFF0;
        repeat (3) cyc();
        check_reset_outs("reset");
        rst_n = 1'b1;
        repeat (2) cyc();

        // Basic 8x4 frame into buffer 0, then a second frame into buffer 1 (wraps).
        cap_en = 1'b1;
        repeat (2) cyc();
        start_frame();
        for (int l = 0; l < 4; l++) send_line(8, 1'b1, -1);
        end_frame(1'b1);
        check_status(8, 4, 1'b0, 1'b0);
        start_frame();
        for (int l = 0; l < 4; l++) send_line(8, 1'b1, -1);
        end_frame(1'b1);
        check_status(8, 4, 1'b0, 1'b0);

        // Short line flags a format error right after that line.
        start_frame();
        send_line(8, 1'b1, -1);
        check_val("fmt_after_good_line", 32'(ferr), 0);
        send_line(7, 1'b1, -1);
        check_val("fmt_after_short_line", 32'(ferr), 1);
        check_val("h_fmt_after_short_line", 32'(h_ferr), 1);
        send_line(8, 1'b1, -1);
        send_line(8, 1'b1, -1);
        end_frame(1'b1);
        check_status(8, 4, 1'b1, 1'b0);
        cap_en = 1'b0;
        repeat (3) cyc();
        check_val("fmt_cleared", 32'({ferr, h_ferr}), 0);

        // Three lines against an expected four: error appears only at frame end.
        cap_en = 1'b1;
        repeat (2) cyc();
        start_frame();
        for (int l = 0; l < 3; l++) send_line(8, 1'b1, -1);
        check_val("fmt_before_done", 32'(ferr), 0);
        end_frame(1'b1);
        check_status(8, 3, 1'b1, 1'b0);
        cap_en = 1'b0;
        repeat (3) cyc();

        // Long stall mid-line overflows the pixel buffer; written beats stay a clean prefix.
        hdisp = 11'd64; vdisp = 11'd2;
        cap_en = 1'b1;
        repeat (2) cyc();
        w0 = n_wr;
        start_frame();
        send_line(64, 1'b1, 16);
        send_line(64, 1'b1, -1);
        end_frame(1'b0);
        check_status(64, 2, 1'b0, 1'b1);
        check_val("ovf_pixels_lost", 32'(q_lo.size() != 0), 1);
        check_val("ovf_some_written", 32'((n_wr - w0) >= 32), 1);
        q_lo.delete();
        q_hi.delete();
        cap_en = 1'b0;
        repeat (3) cyc();
        check_val("ovf_cleared", 32'({ovf, h_ovf}), 0);

        // Capture disabled mid-frame: buffered pixels drain, no frame-done, buffer kept.
        hdisp = 11'd8; vdisp = 11'd4;
        cap_en = 1'b1;
        repeat (2) cyc();
        c0 = fd_cnt;
        start_frame();
        send_line(8, 1'b1, -1);
        send_line(8, 1'b1, -1);
        cap_en = 1'b0;
        send_line(8, 1'b0, -1);
        send_line(8, 1'b0, -1);
        repeat (40) cyc();
        check_val("abort_no_done", 32'(fd_cnt - c0), 0);
        check_val("abort_drained", 32'(q_lo.size()), 0);
        check_val("abort_buf_sel", 32'({bsel, h_bsel}), 32'({exp_buf, exp_buf}));

        // Reset in the middle of a frame with a beat stalled on the bus.
        cap_en = 1'b1;
        repeat (2) cyc();
        start_frame();
        stall_left = 30;
        send_line(4, 1'b0, -1);
        check_val("pre_reset_vd", 32'(vd), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_reset");
        cyc();
        rst_n = 1'b1;
        stall_left = 0;
        exp_buf = 1'b0;
        repeat (3) cyc();

        // Clean frame after reset lands at the start of buffer 0.
        start_frame();
        for (int l = 0; l < 4; l++) send_line(8, 1'b1, -1);
        end_frame(1'b1);
        check_status(8, 4, 1'b0, 1'b0);

        cap_en = 1'b0;
        repeat (5) cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
